// File: rtl/axis_trigger_sequencer.sv
// Triggered AXI-Stream capture sequencer: forwards pre-trigger, delay and post-trigger
// windows of the input stream, closing the post window with tlast.
module axis_trigger_sequencer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        arm_i,
    input  logic                        abort_i,
    input  logic                        soft_trig_i,
    input  logic                        ext_trig_i,
    input  logic [CNTR_WIDTH-1:0]       cfg_pre_i,
    input  logic [CNTR_WIDTH-1:0]       cfg_delay_i,
    input  logic [CNTR_WIDTH-1:0]       cfg_post_i,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                        s_axis_tvalid_i,
    output logic                        s_axis_tready_o,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                        m_axis_tvalid_o,
    output logic                        m_axis_tlast_o,
    input  logic                        m_axis_tready_i,
    output logic                        trigger_o,
    output logic [2:0]                  sts_state_o,
    output logic [CNTR_WIDTH-1:0]       sts_trig_pos_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        DELAY = 3'd3,
        POST  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [CNTR_WIDTH-1:0]   cnt_q;
    logic [CNTR_WIDTH-1:0]   pre_q;
    logic [CNTR_WIDTH-1:0]   delay_q;
    logic [CNTR_WIDTH-1:0]   post_q;
    logic [CNTR_WIDTH-1:0]   trigPos_q;
    logic                    trigger_q;
    logic [2:0]              extSync_q;

    logic                    passThru;
    logic                    xfer;
    logic                    trigEvent;
    logic                    lastBeat;
    logic [CNTR_WIDTH-1:0]   cntInc_d;

    // Outputs are gated by aresetn so the stream is idle while reset is held.
    assign passThru = aresetn && (state_q == PRE || state_q == ARMED ||
                                  state_q == DELAY || state_q == POST);

    assign s_axis_tready_o = passThru ? m_axis_tready_i : 1'b1;
    assign m_axis_tvalid_o = passThru & s_axis_tvalid_i;
    assign m_axis_tdata_o  = s_axis_tdata_i;
    assign xfer            = s_axis_tvalid_i & s_axis_tready_o;

    assign lastBeat       = (state_q == POST) && (post_q != '0) && (cnt_q == post_q - ONE);
    assign m_axis_tlast_o = m_axis_tvalid_o & lastBeat;

    assign trigEvent = (extSync_q[1] & ~extSync_q[2]) | soft_trig_i;
    assign cntInc_d  = (xfer && cnt_q != '1) ? cnt_q + ONE : cnt_q;

    assign trigger_o      = trigger_q;
    assign sts_state_o    = state_q;
    assign sts_trig_pos_o = trigPos_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            delay_q   <= '0;
            post_q    <= '0;
            trigPos_q <= '0;
            trigger_q <= 1'b0;
            extSync_q <= '0;
        end else begin
            extSync_q <= {extSync_q[1:0], ext_trig_i};
            trigger_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (arm_i) begin
                            pre_q   <= cfg_pre_i;
                            delay_q <= cfg_delay_i;
                            post_q  <= cfg_post_i;
                            cnt_q   <= '0;
                            state_q <= PRE;
                        end
                    end
                    PRE: begin
                        cnt_q <= cntInc_d;
                        if (cntInc_d >= pre_q) state_q <= ARMED;
                    end
                    // The counter keeps running from PRE so it holds the total since arm.
                    ARMED: begin
                        cnt_q <= cntInc_d;
                        if (trigEvent) begin
                            trigPos_q <= cntInc_d;
                            cnt_q     <= '0;
                            state_q   <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (delay_q == '0 || cnt_q == delay_q - ONE) begin
                            cnt_q     <= '0;
                            trigger_q <= 1'b1;
                            state_q   <= POST;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    POST: begin
                        if (post_q == '0) begin
                            state_q <= DONE;
                        end else if (xfer) begin
                            cnt_q <= cnt_q + ONE;
                            if (lastBeat) state_q <= DONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_trigger_sequencer.sv
// Directed scoreboard bench for axis_trigger_sequencer: expected beats are queued as
// stimulus is issued and a forked monitor checks every output handshake.
module tb_axis_trigger_sequencer;

    localparam int DW = 32;
    localparam int CW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          softTrig = 1'b0;
    logic          extTrig = 1'b0;
    logic [CW-1:0] cfgPre = '0;
    logic [CW-1:0] cfgDelay = '0;
    logic [CW-1:0] cfgPost = '0;
    logic [DW-1:0] srcData = 32'h100;
    logic          sValid = 1'b1;
    logic          sReady;
    logic [DW-1:0] mData;
    logic          mValid;
    logic          mLast;
    logic          mReady = 1'b1;
    logic          trigger;
    logic [2:0]    stsState;
    logic [CW-1:0] stsTrigPos;

    beat_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    axis_trigger_sequencer #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .arm_i          (arm),
        .abort_i        (abort),
        .soft_trig_i    (softTrig),
        .ext_trig_i     (extTrig),
        .cfg_pre_i      (cfgPre),
        .cfg_delay_i    (cfgDelay),
        .cfg_post_i     (cfgPost),
        .s_axis_tdata_i (srcData),
        .s_axis_tvalid_i(sValid),
        .s_axis_tready_o(sReady),
        .m_axis_tdata_o (mData),
        .m_axis_tvalid_o(mValid),
        .m_axis_tlast_o (mLast),
        .m_axis_tready_i(mReady),
        .trigger_o      (trigger),
        .sts_state_o    (stsState),
        .sts_trig_pos_o (stsTrigPos)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run n cycles; when fwd is set every accepted input beat is expected on the output.
    task automatic applyStimulus(input int n, input bit fwd);
        bit took;
        for (int i = 0; i < n; i++) begin
            #1;
            took = sValid && sReady;
            if (fwd && took) expQ.push_back('{data: srcData, last: 1'b0});
            @(posedge aclk);
            #1;
            if (took) srcData = srcData + 1;
        end
    endtask

    // Run until n beats are forwarded, optionally toggling m_tready every cycle.
    task automatic runXfers(input string name, input int n, input bit toggle, input bit lastOnFinal);
        bit took;
        int cnt = 0;
        int k = 0;
        while (cnt < n && k < 200) begin
            mReady = toggle ? k[0] : 1'b1;
            #1;
            took = sValid && sReady;
            if (took) begin
                expQ.push_back('{data: srcData, last: lastOnFinal && (cnt == n - 1)});
                cnt++;
            end
            @(posedge aclk);
            #1;
            if (took) srcData = srcData + 1;
            k++;
        end
        mReady = 1'b1;
        checkOutput({name, "_beats"}, 64'(cnt), 64'(n));
    endtask

    initial begin
        fork
            forever begin
                @(negedge aclk);
                if (mValid && mReady) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got data %0h last %0b expected no beat", mData, mLast);
                    end else begin
                        beat_t e;
                        e = expQ.pop_front();
                        if (mData !== e.data || mLast !== e.last) begin
                            errors++;
                            $display("[TB] FAIL beat: got data %0h last %0b expected data %0h last %0b",
                                     mData, mLast, e.data, e.last);
                        end
                    end
                end
            end
        join_none

        // Reset values
        applyStimulus(3, 1'b0);
        checkOutput("rst_tvalid", 64'(mValid), 64'd0);
        checkOutput("rst_tlast", 64'(mLast), 64'd0);
        checkOutput("rst_tready", 64'(sReady), 64'd1);
        checkOutput("rst_state", 64'(stsState), 64'd0);
        checkOutput("rst_trigger", 64'(trigger), 64'd0);
        checkOutput("rst_trigpos", 64'(stsTrigPos), 64'd0);
        aresetn = 1'b1;
        applyStimulus(2, 1'b0);
        checkOutput("idle_tvalid", 64'(mValid), 64'd0);

        // Nominal: pre=4 delay=3 post=8, soft trigger on third ARMED cycle
        cfgPre = 4; cfgDelay = 3; cfgPost = 8;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        cfgPre = 1; cfgDelay = 9; cfgPost = 1;
        checkOutput("nom_pre", 64'(stsState), 64'd1);
        applyStimulus(4, 1'b1);
        checkOutput("nom_armed", 64'(stsState), 64'd2);
        applyStimulus(2, 1'b1);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        checkOutput("nom_delay", 64'(stsState), 64'd3);
        checkOutput("nom_trigpos", 64'(stsTrigPos), 64'd7);
        applyStimulus(2, 1'b1);
        checkOutput("nom_delay_len", 64'(stsState), 64'd3);
        checkOutput("nom_trig_early", 64'(trigger), 64'd0);
        applyStimulus(1, 1'b1);
        checkOutput("nom_post", 64'(stsState), 64'd4);
        checkOutput("nom_trigger", 64'(trigger), 64'd1);
        runXfers("nom_post", 8, 1'b0, 1'b1);
        checkOutput("nom_done", 64'(stsState), 64'd5);
        checkOutput("nom_trig_clear", 64'(trigger), 64'd0);
        checkOutput("nom_done_tvalid", 64'(mValid), 64'd0);

        // Backpressure: m_tready toggles in PRE and POST
        cfgPre = 4; cfgDelay = 2; cfgPost = 8;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        runXfers("bp_pre", 4, 1'b1, 1'b0);
        checkOutput("bp_armed", 64'(stsState), 64'd2);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        checkOutput("bp_trigpos", 64'(stsTrigPos), 64'd5);
        applyStimulus(2, 1'b1);
        checkOutput("bp_post", 64'(stsState), 64'd4);
        runXfers("bp_post", 8, 1'b1, 1'b1);
        checkOutput("bp_done", 64'(stsState), 64'd5);

        // Early external trigger during PRE is ignored; second rise in ARMED accepted
        cfgPre = 4; cfgDelay = 1; cfgPost = 2;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        extTrig = 1'b1;
        applyStimulus(4, 1'b1);
        extTrig = 1'b0;
        checkOutput("early_armed", 64'(stsState), 64'd2);
        applyStimulus(3, 1'b1);
        checkOutput("early_ignored", 64'(stsState), 64'd2);
        extTrig = 1'b1;
        applyStimulus(2, 1'b1);
        checkOutput("early_sync_lat", 64'(stsState), 64'd2);
        applyStimulus(1, 1'b1);
        extTrig = 1'b0;
        checkOutput("early_delay", 64'(stsState), 64'd3);
        checkOutput("early_trigpos", 64'(stsTrigPos), 64'd10);
        applyStimulus(1, 1'b1);
        checkOutput("early_trigger", 64'(trigger), 64'd1);
        runXfers("early_post", 2, 1'b0, 1'b1);
        checkOutput("early_done", 64'(stsState), 64'd5);

        // Zero configuration: one cycle per phase, no tlast
        cfgPre = 0; cfgDelay = 0; cfgPost = 0;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        checkOutput("zero_pre", 64'(stsState), 64'd1);
        applyStimulus(1, 1'b1);
        checkOutput("zero_armed", 64'(stsState), 64'd2);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        checkOutput("zero_delay", 64'(stsState), 64'd3);
        checkOutput("zero_trigpos", 64'(stsTrigPos), 64'd2);
        applyStimulus(1, 1'b1);
        checkOutput("zero_post", 64'(stsState), 64'd4);
        checkOutput("zero_trigger", 64'(trigger), 64'd1);
        applyStimulus(1, 1'b1);
        checkOutput("zero_done", 64'(stsState), 64'd5);

        // Abort in POST after 3 beats
        cfgPre = 1; cfgDelay = 0; cfgPost = 8;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        applyStimulus(1, 1'b1);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        applyStimulus(1, 1'b1);
        checkOutput("abort_post", 64'(stsState), 64'd4);
        applyStimulus(3, 1'b1);
        abort = 1'b1;
        applyStimulus(1, 1'b1);
        abort = 1'b0;
        checkOutput("abort_idle", 64'(stsState), 64'd0);
        checkOutput("abort_tvalid", 64'(mValid), 64'd0);
        checkOutput("abort_tlast", 64'(mLast), 64'd0);

        // Reset in POST after 3 beats
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        applyStimulus(1, 1'b1);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        applyStimulus(4, 1'b1);
        checkOutput("mrst_trigpos_pre", 64'(stsTrigPos), 64'd2);
        aresetn = 1'b0;
        #1;
        checkOutput("mrst_tvalid", 64'(mValid), 64'd0);
        checkOutput("mrst_tready", 64'(sReady), 64'd1);
        applyStimulus(1, 1'b0);
        aresetn = 1'b1;
        checkOutput("mrst_state", 64'(stsState), 64'd0);
        checkOutput("mrst_trigpos", 64'(stsTrigPos), 64'd0);
        checkOutput("mrst_trigger", 64'(trigger), 64'd0);
        checkOutput("mrst_tlast", 64'(mLast), 64'd0);

        // Re-arm from DONE with a new post count; arm while ARMED is ignored
        cfgPre = 0; cfgDelay = 0; cfgPost = 3;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        applyStimulus(1, 1'b1);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        applyStimulus(1, 1'b1);
        runXfers("rearm_first", 3, 1'b0, 1'b1);
        checkOutput("rearm_done1", 64'(stsState), 64'd5);
        cfgPost = 2;
        arm = 1'b1;
        applyStimulus(1, 1'b0);
        arm = 1'b0;
        cfgPost = 5;
        applyStimulus(1, 1'b1);
        checkOutput("rearm_armed", 64'(stsState), 64'd2);
        arm = 1'b1;
        applyStimulus(1, 1'b1);
        arm = 1'b0;
        checkOutput("rearm_busy_arm", 64'(stsState), 64'd2);
        softTrig = 1'b1;
        applyStimulus(1, 1'b1);
        softTrig = 1'b0;
        applyStimulus(1, 1'b1);
        runXfers("rearm_second", 2, 1'b0, 1'b1);
        checkOutput("rearm_done2", 64'(stsState), 64'd5);

        applyStimulus(2, 1'b0);
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_trigger_sequencer.md
AXIS_TRIGGER_SEQUENCER -- requirements
Module: axis_trigger_sequencer

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, AXI-Stream data width in bits.
REQ-002 Parameter CNTR_WIDTH, default 32, width of all sample and delay counters and count inputs.
REQ-003 aclk  in  1  clock; all logic rising-edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 arm  in  1  single-cycle start pulse.
REQ-006 abort  in  1  single-cycle pulse; returns the block to IDLE.
REQ-007 soft_trig  in  1  software trigger level.
REQ-008 ext_trig  in  1  asynchronous external trigger level.
REQ-009 cfg_pre  in  CNTR_WIDTH  pre-trigger transfer count.
REQ-010 cfg_delay  in  CNTR_WIDTH  trigger-to-capture delay in aclk cycles.
REQ-011 cfg_post  in  CNTR_WIDTH  post-trigger transfer count.
REQ-012 s_axis_tdata/tvalid  in  AXIS_TDATA_WIDTH/1; s_axis_tready  out  1.
REQ-013 m_axis_tdata/tvalid/tlast  out  AXIS_TDATA_WIDTH/1/1; m_axis_tready  in  1.
REQ-014 trigger  out  1  one-cycle pulse when the POST phase begins.
REQ-015 sts_state  out  3  state encoding: IDLE=0, PRE=1, ARMED=2, DELAY=3, POST=4, DONE=5.
REQ-016 sts_trig_pos  out  CNTR_WIDTH  transfers forwarded before the trigger was accepted.

Function
REQ-017 Transfer = s_axis_tvalid & s_axis_tready in the same cycle.
REQ-018 IDLE/DONE: s_axis_tready=1, m_axis_tvalid=0, input discarded.
REQ-019 PRE/ARMED/DELAY/POST: combinational pass-through, zero latency (m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready).
REQ-020 ext_trig passes through a 2-FF synchronizer; the trigger event is the rising edge of the synchronized signal OR soft_trig high.
REQ-021 IDLE or DONE + arm -> PRE with counter cleared; a trigger event in these states is ignored.
REQ-022 PRE: counter increments per transfer; when the count reaches cfg_pre -> ARMED; cfg_pre=0 goes PRE->ARMED on the next cycle.
REQ-023 ARMED: a trigger event -> DELAY; sts_trig_pos latches the total transfers forwarded since arm, including the same-cycle transfer.
REQ-024 DELAY: counts aclk cycles independent of handshake; after cfg_delay cycles -> POST; cfg_delay=0 -> POST on the next cycle.
REQ-025 trigger=1 for exactly the cycle of entry into POST.
REQ-026 POST: counts transfers; m_axis_tlast=1 on the cfg_post-th transfer, then -> DONE; cfg_post=0 -> DONE next cycle with no tlast.
REQ-027 m_axis_tlast=0 in all other cycles.
REQ-028 Config inputs are sampled into registers on arm; changes mid-sequence have no effect.
REQ-029 abort has priority over all transitions -> IDLE next cycle; no tlast is emitted.
REQ-030 arm while busy (PRE..POST) is ignored.
REQ-031 Counters saturate at all-ones and do not wrap.

Reset
REQ-032 On aresetn=0 at a clock edge: state=IDLE, counters=0, sts_trig_pos=0, trigger=0, synchronizer flops=0.
REQ-033 Reset asserted mid-sequence aborts as in REQ-029; the next cycle shows the IDLE outputs of REQ-018.
REQ-034 Outputs during reset: m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1.

Verification
REQ-035 Nominal: pre=4, delay=3, post=8, continuous valid/ready, soft_trig 2 cycles after ARMED -> trigger pulse 3 cycles after the event; tlast on the 8th POST transfer; DONE.
REQ-036 Backpressure: m_tready toggles 50% in PRE/POST -> no beats lost or duplicated; exactly 8 POST beats; data matches the input order.
REQ-037 Early trigger: ext_trig rises during PRE -> ignored; a second rise in ARMED accepted; sts_trig_pos = pre + extra ARMED transfers.
REQ-038 Zero configs: pre=0, delay=0, post=0 -> PRE->ARMED->(trigger)->DELAY->POST->DONE, one cycle each; trigger pulses; no tlast.
REQ-039 Abort/reset: abort during POST after 3 beats -> IDLE next cycle, tvalid=0, no tlast; repeat with aresetn=0 -> all REQ-032 values.
REQ-040 Re-arm: arm in DONE with new cfg_post=2 -> the new sequence uses 2; arm while ARMED -> no state change.
